// File: rtl/ps2_pkg.sv
// Shared scan-code and ASCII constants for the PS/2 key queue.
package ps2_pkg;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] scan;
  } ps2_code_t;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_ESC    = 8'h76;

  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_BS  = 8'h08;
  localparam logic [7:0] ASCII_ESC = 8'h1B;
  localparam logic [7:0] ASCII_SP  = 8'h20;

endpackage

// File: rtl/ps2_scan_to_ascii.sv
// Combinational set-2 scan code to ASCII lookup; hit=0 for untranslated codes.
module ps2_scan_to_ascii
  import ps2_pkg::*;
(
  input  logic [7:0] scan_i,
  input  logic       ext_i,
  input  logic       upper_i,
  output logic       hit_o,
  output logic [7:0] ascii_o
);

  logic       letter;
  logic [7:0] base;

  always_comb begin
    letter = 1'b1;
    base   = 8'h00;
    case (scan_i)
      8'h1C: base = 8'h61;
      8'h32: base = 8'h62;
      8'h21: base = 8'h63;
      8'h23: base = 8'h64;
      8'h24: base = 8'h65;
      8'h2B: base = 8'h66;
      8'h34: base = 8'h67;
      8'h33: base = 8'h68;
      8'h43: base = 8'h69;
      8'h3B: base = 8'h6A;
      8'h42: base = 8'h6B;
      8'h4B: base = 8'h6C;
      8'h3A: base = 8'h6D;
      8'h31: base = 8'h6E;
      8'h44: base = 8'h6F;
      8'h4D: base = 8'h70;
      8'h15: base = 8'h71;
      8'h2D: base = 8'h72;
      8'h1B: base = 8'h73;
      8'h2C: base = 8'h74;
      8'h3C: base = 8'h75;
      8'h2A: base = 8'h76;
      8'h1D: base = 8'h77;
      8'h22: base = 8'h78;
      8'h35: base = 8'h79;
      8'h1A: base = 8'h7A;
      default: letter = 1'b0;
    endcase
  end

  always_comb begin
    hit_o   = 1'b1;
    ascii_o = 8'h00;
    if (ext_i) begin
      // Only keypad Enter is translated from the extended set.
      hit_o   = (scan_i == SC_ENTER);
      ascii_o = hit_o ? ASCII_CR : 8'h00;
    end else if (letter) begin
      ascii_o = upper_i ? (base - 8'h20) : base;
    end else begin
      case (scan_i)
        8'h45:    ascii_o = 8'h30;
        8'h16:    ascii_o = 8'h31;
        8'h1E:    ascii_o = 8'h32;
        8'h26:    ascii_o = 8'h33;
        8'h25:    ascii_o = 8'h34;
        8'h2E:    ascii_o = 8'h35;
        8'h36:    ascii_o = 8'h36;
        8'h3D:    ascii_o = 8'h37;
        8'h3E:    ascii_o = 8'h38;
        8'h46:    ascii_o = 8'h39;
        SC_SPACE: ascii_o = ASCII_SP;
        SC_ENTER: ascii_o = ASCII_CR;
        SC_BKSP:  ascii_o = ASCII_BS;
        SC_ESC:   ascii_o = ASCII_ESC;
        default:  hit_o   = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_queue.sv
// Tracks Shift/Caps Lock, translates PS/2 make codes to ASCII and queues them
// in a first-word fall-through FIFO with a sticky overflow flag.
module ps2_key_queue
  import ps2_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          code_valid,
  input  logic [9:0]    code,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  output logic [AW:0]   count,
  output logic          shift_held,
  output logic          caps_lock,
  output logic          overflow,
  input  logic          clr_ovf
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  ps2_code_t c;
  assign c = code;

  logic lshift_q, lshift_d, rshift_q, rshift_d;
  logic caps_q, caps_d, caps_down_q, caps_down_d;
  logic push_q, push_d;
  logic [7:0] ascii_q, ascii_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic ovf_q, ovf_d;
  logic [7:0] mem [DEPTH];

  logic       tr_hit;
  logic [7:0] tr_ascii;
  logic       full, pop, wr;

  // Case is decided from the modifier state held before this code arrives.
  ps2_scan_to_ascii u_xlat (
    .scan_i  (c.scan),
    .ext_i   (c.ext),
    .upper_i ((lshift_q | rshift_q) ^ caps_q),
    .hit_o   (tr_hit),
    .ascii_o (tr_ascii)
  );

  always_comb begin
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    caps_d      = caps_q;
    caps_down_d = caps_down_q;
    push_d      = code_valid & ~c.brk & tr_hit;
    ascii_d     = tr_ascii;
    if (code_valid && !c.ext) begin
      case (c.scan)
        SC_LSHIFT: lshift_d = ~c.brk;
        SC_RSHIFT: rshift_d = ~c.brk;
        SC_CAPS: begin
          // Typematic repeats of Caps Lock arrive as makes with the key still down.
          if (c.brk) begin
            caps_down_d = 1'b0;
          end else if (!caps_down_q) begin
            caps_d      = ~caps_q;
            caps_down_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign count    = wr_ptr_q - rd_ptr_q;
  assign full     = (count == FULL_CNT);
  assign rd_valid = (count != '0);
  assign pop      = rd_en & rd_valid;
  assign wr       = push_q & (~full | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (wr)  wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (clr_ovf) ovf_d = 1'b0;
    if (push_q && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      caps_q      <= 1'b0;
      caps_down_q <= 1'b0;
      push_q      <= 1'b0;
      ascii_q     <= 8'h00;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ovf_q       <= 1'b0;
    end else begin
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      caps_q      <= caps_d;
      caps_down_q <= caps_down_d;
      push_q      <= push_d;
      ascii_q     <= ascii_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr_q[AW-1:0]] <= ascii_q;
  end

  assign rd_data    = rd_valid ? mem[rd_ptr_q[AW-1:0]] : 8'h00;
  assign shift_held = lshift_q | rshift_q;
  assign caps_lock  = caps_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_key_queue.sv
// Directed scenarios plus randomized traffic against a queue-based reference model.
module tb_ps2_key_queue;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          code_valid = 1'b0;
  logic [9:0]    code = 10'h000;
  logic          rd_en = 1'b0;
  logic          clr_ovf = 1'b0;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic [AW:0]   count;
  logic          shift_held, caps_lock, overflow;

  always #5 clk = ~clk;

  ps2_key_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .code_valid (code_valid),
    .code       (code),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .count      (count),
    .shift_held (shift_held),
    .caps_lock  (caps_lock),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference tables: scan code -> character.
  logic [7:0] let_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                              8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                              8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] dig_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] letter_lut [logic [7:0]];
  logic [7:0] other_lut  [logic [7:0]];
  logic [7:0] pool [$];

  // Reference model state; exp_q is the expected FIFO contents, head first.
  logic [7:0] exp_q [$];
  logic       m_ls = 1'b0, m_rs = 1'b0, m_caps = 1'b0, m_caps_dn = 1'b0, m_ovf = 1'b0;
  logic       m_pend_v = 1'b0;
  logic [7:0] m_pend = 8'h00;

  task automatic model_code(input logic [9:0] cw);
    logic       ext, brk, upper;
    logic [7:0] sc;
    ext   = cw[9];
    brk   = cw[8];
    sc    = cw[7:0];
    upper = (m_ls | m_rs) ^ m_caps;
    if (!ext) begin
      if (sc == 8'h12) m_ls = !brk;
      if (sc == 8'h59) m_rs = !brk;
      if (sc == 8'h58) begin
        if (brk) m_caps_dn = 1'b0;
        else if (!m_caps_dn) begin
          m_caps    = !m_caps;
          m_caps_dn = 1'b1;
        end
      end
    end
    if (!brk) begin
      if (ext) begin
        if (sc == 8'h5A) begin m_pend_v = 1'b1; m_pend = 8'h0D; end
      end else if (letter_lut.exists(sc)) begin
        m_pend_v = 1'b1;
        m_pend   = upper ? letter_lut[sc] - 8'd32 : letter_lut[sc];
      end else if (other_lut.exists(sc)) begin
        m_pend_v = 1'b1;
        m_pend   = other_lut[sc];
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_ls = 1'b0; m_rs = 1'b0; m_caps = 1'b0; m_caps_dn = 1'b0; m_ovf = 1'b0;
      m_pend_v = 1'b0;
    end else begin
      if (rd_en && exp_q.size() > 0) void'(exp_q.pop_front());
      if (clr_ovf) m_ovf = 1'b0;
      if (m_pend_v) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(m_pend);
        else m_ovf = 1'b1;
      end
      m_pend_v = 1'b0;
      if (code_valid) model_code(code);
    end
  end

  // Monitor: compares every observable output against the model each cycle.
  always @(negedge clk) begin
    chk("count", 16'(count), 16'(exp_q.size()));
    chk("rd_valid", 16'(rd_valid), 16'(exp_q.size() != 0));
    chk("rd_data", 16'(rd_data), (exp_q.size() != 0) ? 16'(exp_q[0]) : 16'h0000);
    chk("shift_held", 16'(shift_held), 16'(m_ls | m_rs));
    chk("caps_lock", 16'(caps_lock), 16'(m_caps));
    chk("overflow", 16'(overflow), 16'(m_ovf));
  end

  task automatic tick(input logic cv, input logic [9:0] c, input logic rd, input logic clr);
    code_valid = cv;
    code       = c;
    rd_en      = rd;
    clr_ovf    = clr;
    @(posedge clk);
    #1;
    code_valid = 1'b0;
    rd_en      = 1'b0;
    clr_ovf    = 1'b0;
  endtask

  task automatic strobe(input logic [9:0] c);
    tick(1'b1, c, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 10'h000, 1'b0, 1'b0);
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 10'h000, 1'b1, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 26; i++) begin
      letter_lut[let_sc[i]] = 8'h61 + 8'(i);
      pool.push_back(let_sc[i]);
    end
    for (int i = 0; i < 10; i++) begin
      other_lut[dig_sc[i]] = 8'h30 + 8'(i);
      pool.push_back(dig_sc[i]);
    end
    other_lut[8'h29] = 8'h20;
    other_lut[8'h5A] = 8'h0D;
    other_lut[8'h66] = 8'h08;
    other_lut[8'h76] = 8'h1B;
    pool.push_back(8'h29); pool.push_back(8'h5A); pool.push_back(8'h66);
    pool.push_back(8'h76); pool.push_back(8'h12); pool.push_back(8'h59);
    pool.push_back(8'h58);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", 16'(count), 16'h0000);
    chk("reset_rd_data", 16'(rd_data), 16'h0000);
    rst = 1'b0;

    // Single letter, two-clock latency, then pop back to empty.
    strobe(10'h01C);
    chk("lat1_valid", 16'(rd_valid), 16'h0000);
    idle(1);
    chk("t1_valid", 16'(rd_valid), 16'h0001);
    chk("t1_data", 16'(rd_data), 16'h0061);
    chk("t1_count", 16'(count), 16'h0001);
    pop_n(1);
    chk("t1_empty_data", 16'(rd_data), 16'h0000);
    chk("t1_empty_valid", 16'(rd_valid), 16'h0000);

    // Shift make/break around letters.
    strobe(10'h012);
    chk("t2_shift_on", 16'(shift_held), 16'h0001);
    strobe(10'h01C);
    strobe(10'h112);
    chk("t2_shift_off", 16'(shift_held), 16'h0000);
    strobe(10'h01C);
    idle(2);
    chk("t2_first", 16'(rd_data), 16'h0041);
    pop_n(1);
    chk("t2_second", 16'(rd_data), 16'h0061);
    pop_n(1);

    // Caps Lock with a typematic repeat, then Shift cancels it.
    strobe(10'h058); strobe(10'h058); strobe(10'h158);
    strobe(10'h012); strobe(10'h01C); strobe(10'h112);
    idle(2);
    chk("t3_caps", 16'(caps_lock), 16'h0001);
    chk("t3_data", 16'(rd_data), 16'h0061);
    pop_n(1);
    strobe(10'h058); strobe(10'h158);
    chk("t3_caps_off", 16'(caps_lock), 16'h0000);

    // Overflow on the 17th character, sticky until cleared.
    for (int i = 0; i < 17; i++) strobe({2'b00, let_sc[i]});
    idle(2);
    chk("t4_count", 16'(count), 16'h0010);
    chk("t4_ovf", 16'(overflow), 16'h0001);
    tick(1'b0, 10'h000, 1'b0, 1'b1);
    chk("t4_ovf_clr", 16'(overflow), 16'h0000);
    chk("t4_head", 16'(rd_data), 16'h0061);
    pop_n(16);

    // Full FIFO with push and pop on the same edge.
    for (int i = 0; i < 16; i++) strobe({2'b00, let_sc[i]});
    idle(2);
    strobe(10'h01A);
    tick(1'b0, 10'h000, 1'b1, 1'b0);
    chk("t5_count", 16'(count), 16'h0010);
    chk("t5_ovf", 16'(overflow), 16'h0000);
    chk("t5_head", 16'(rd_data), 16'h0062);
    pop_n(16);

    // Extended/break/junk codes, then reset with a character in flight.
    strobe(10'h15A); strobe(10'h25A); strobe(10'h11C); strobe(10'h007);
    idle(2);
    chk("t6_count", 16'(count), 16'h0001);
    chk("t6_data", 16'(rd_data), 16'h000D);
    strobe(10'h012); strobe(10'h032); strobe(10'h01C);
    rst = 1'b1;
    #2;
    chk("t6_rst_count", 16'(count), 16'h0000);
    chk("t6_rst_shift", 16'(shift_held), 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    chk("t6_inflight", 16'(count), 16'h0000);

    // Randomized traffic with varying read pressure to visit empty and full.
    for (int ph = 0; ph < 15; ph++) begin
      int rd_pct;
      rd_pct = $urandom_range(0, 100);
      for (int i = 0; i < 200; i++) begin
        logic [7:0] sc;
        logic       ext, brk, cv;
        if ($urandom_range(0, 9) < 6) sc = pool[$urandom_range(0, pool.size() - 1)];
        else sc = 8'($urandom_range(0, 255));
        ext = ($urandom_range(0, 9) == 0);
        brk = ($urandom_range(0, 3) == 0);
        cv  = ($urandom_range(0, 9) < 7);
        tick(cv, {ext, brk, sc}, ($urandom_range(0, 99) < rd_pct),
             ($urandom_range(0, 31) == 0));
      end
    end
    pop_n(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
